// File: rtl/div24u_seq.sv
// div24u_seq: sequential 24/12 unsigned restoring divider with valid/ready I/O.
// Define DIV24U_TRUNC_EN to zero dividend bits [9:0] at capture.
module div24u_seq #(
  parameter int ITERS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] D,
  input  logic [11:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] Q,
  output logic [11:0] R,
  output logic        dbz,
  output logic        ovf
);

  localparam int NCYC =
    (12 + ITERS_PER_CYCLE - 1) / ITERS_PER_CYCLE;
  localparam logic [3:0] CNT_LOAD = 4'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] rem_q, rem_d;
  logic [11:0] sh_q, sh_d;
  logic [11:0] b_q, b_d;
  logic [11:0] q_q, q_d;
  logic [11:0] r_q, r_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;
  logic        vld_q, vld_d;

  logic [23:0] d_eff;
  logic [11:0] b_src, rem_src, sh_src;
  logic [11:0] rem_nx, sh_nx;
  logic [12:0] t;
  logic        accept, is_dbz, is_ovf;

`ifdef DIV24U_TRUNC_EN
  assign d_eff = {D[23:10], 10'b0};
`else
  assign d_eff = D;
`endif

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign is_dbz    = (B == 12'd0);
  assign is_ovf    = !is_dbz && (D[23:12] >= B);
  assign out_valid = vld_q;
  assign Q         = q_q;
  assign R         = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

  // The accept edge already retires the first group of
  // quotient bits, straight from the input operands.
  always_comb begin
    b_src   = in_ready ? B : b_q;
    rem_src = in_ready ? d_eff[23:12] : rem_q;
    sh_src  = in_ready ? d_eff[11:0] : sh_q;
    rem_nx  = rem_src;
    sh_nx   = sh_src;
    t       = '0;
    for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
      t     = {rem_nx, sh_nx[11]};
      sh_nx = {sh_nx[10:0], 1'b0};
      if (t >= {1'b0, b_src}) begin
        t        = t - {1'b0, b_src};
        sh_nx[0] = 1'b1;
      end
      rem_nx = t[11:0];
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          b_d = B;
          if (is_dbz) begin
            state_d = DONE;
            vld_d   = 1'b1;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            q_d     = 12'hFFF;
            r_d     = d_eff[11:0];
          end else if (is_ovf) begin
            state_d = DONE;
            vld_d   = 1'b1;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            q_d     = 12'hFFF;
            r_d     = 12'd0;
          end else begin
            state_d = CALC;
            rem_d   = rem_nx;
            sh_d    = sh_nx;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx;
        sh_d  = sh_nx;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          vld_d   = 1'b1;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          q_d     = sh_nx;
          r_d     = rem_nx;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_div24u_seq.sv
// tb_div24u_seq: directed vector table against two divider instances,
// one bit per clock and four bits per clock, plus handshake/reset sequences.
module tb_div24u_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] D;
  logic [11:0] B;
  logic        out_ready;

  logic        ir1, ov1, dz1, of1;
  logic [11:0] q1, r1;
  logic        ir4, ov4, dz4, of4;
  logic [11:0] q4, r4;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef DIV24U_TRUNC_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  always #5 clk = ~clk;

  div24u_seq #(.ITERS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir1),
    .D(D), .B(B),
    .out_valid(ov1), .out_ready(out_ready),
    .Q(q1), .R(r1), .dbz(dz1), .ovf(of1)
  );

  div24u_seq #(.ITERS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir4),
    .D(D), .B(B),
    .out_valid(ov4), .out_ready(out_ready),
    .Q(q4), .R(r4), .dbz(dz4), .ovf(of4)
  );

  typedef struct {
    logic [23:0] d;
    logic [11:0] b;
    logic [11:0] q;
    logic [11:0] r;
    logic        dz;
    logic        ov;
    logic        direct;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    int lat1, lat4;
    string tag;
    tag = $sformatf("v%0d", idx);
    in_valid  = 1'b1;
    D         = v.d;
    B         = v.b;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    D        = 24'hA5A5A5;
    B        = 12'h5A5;
    lat1 = 0;
    lat4 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (ov1 && lat1 == 0) lat1 = c;
      if (ov4 && lat4 == 0) lat4 = c;
      if (lat1 != 0 && lat4 != 0) break;
      @(posedge clk); #1;
    end
    chk({tag, " lat1"}, lat1, v.direct ? 1 : 12);
    chk({tag, " lat4"}, lat4, v.direct ? 1 : 3);
    chk({tag, " Q1"}, int'(q1), int'(v.q));
    chk({tag, " R1"}, int'(r1), int'(v.r));
    chk({tag, " dbz1"}, int'(dz1), int'(v.dz));
    chk({tag, " ovf1"}, int'(of1), int'(v.ov));
    chk({tag, " Q4"}, int'(q4), int'(v.q));
    chk({tag, " R4"}, int'(r4), int'(v.r));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " idle1"}, int'(ir1), 1);
    chk({tag, " idle4"}, int'(ir4), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vec_t h;
    vt[0] = '{24'h0F4240, 12'h3E8,
              TR ? 12'h3E7 : 12'h3E8,
              TR ? 12'h1A8 : 12'h000, 1'b0, 1'b0, 1'b0};
    vt[1] = '{24'h123456, 12'h000, 12'hFFF,
              TR ? 12'h400 : 12'h456, 1'b1, 1'b0, 1'b1};
    vt[2] = '{24'hFFFFFF, 12'hFFF, 12'hFFF, 12'h000,
              1'b0, 1'b1, 1'b1};
    vt[3] = '{24'hFFEFFF, 12'hFFF, 12'hFFF,
              TR ? 12'hBFF : 12'hFFE, 1'b0, 1'b0, 1'b0};
    vt[4] = '{24'h0F43FF, 12'h3E8,
              TR ? 12'h3E7 : 12'h3E8,
              TR ? 12'h1A8 : 12'h1BF, 1'b0, 1'b0, 1'b0};
    vt[5] = '{24'h000400, 12'h003, 12'h155, 12'h001,
              1'b0, 1'b0, 1'b0};
    vt[6] = '{24'h0AB000, 12'h0AC, 12'hFE8, 12'h020,
              1'b0, 1'b0, 1'b0};
    vt[7] = '{24'h005000, 12'h005, 12'hFFF, 12'h000,
              1'b0, 1'b1, 1'b1};
    vt[8] = '{24'h000000, 12'h000, 12'hFFF, 12'h000,
              1'b1, 1'b0, 1'b1};
    vt[9] = '{24'h000C00, 12'h001, 12'hC00, 12'h000,
              1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    D         = '0;
    B         = '0;
    #12;
    chk("rst out_valid", int'(ov1), 0);
    chk("rst in_ready", int'(ir1), 1);
    chk("rst Q", int'(q1), 0);
    chk("rst R", int'(r1), 0);
    chk("rst flags", int'({dz1, of1}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst in_ready", int'(ir1), 1);

    for (int i = 0; i < 10; i++) run_op(i, vt[i]);

    // Result held under back-pressure; inputs ignored in DONE.
    in_valid  = 1'b1;
    D         = 24'h0F4240;
    B         = 12'h3E8;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!ov1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold reached", int'(ov1), 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      D        = 24'h000C00;
      B        = 12'h001;
      @(posedge clk); #1;
      chk("hold valid", int'(ov1), 1);
      chk("hold ready", int'(ir1), 0);
      chk("hold Q", int'(q1), int'(vt[0].q));
      chk("hold R", int'(r1), int'(vt[0].r));
      chk("hold flags", int'({dz1, of1}), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release valid", int'(ov1), 0);
    chk("release ready", int'(ir1), 1);

    // Reset in the middle of a computation.
    in_valid = 1'b1;
    D        = 24'h000400;
    B        = 12'h003;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
    end
    chk("calc busy", int'(ir1), 0);
    rst_n = 1'b0;
    #1;
    chk("abort valid", int'(ov1), 0);
    chk("abort ready", int'(ir1), 1);
    chk("abort Q", int'(q1), 0);
    chk("abort R", int'(r1), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("abort rel ready", int'(ir1), 1);
    chk("abort rel valid", int'(ov1), 0);
    @(posedge clk); #1;
    h = vt[6];
    run_op(10, h);
    h = vt[4];
    run_op(11, h);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
